// File: rtl/cw_vc_input.sv
// cw_vc_input -- clockwise input port of the ring router.
//
// Flits arriving on the clockwise link are buffered into NUM_VC independent
// circular FIFOs; the VC written is the one selected by the current phase.
// Every non-empty VC that is not the phase VC requests either the clockwise
// output (hop != 0, flit forwarded with hop decremented) or the PE output
// (hop == 0, flit delivered unchanged).
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-low reset
//   phase      current phase, selects the VC that is written
//   cwsi/cwri  upstream valid / ready (ready = VC[phase] not full)
//   cwdi       upstream flit
//   request_cw per-VC request to the clockwise output arbiter
//   request_pe per-VC request to the PE output arbiter
//   grant_cw   per-VC grant from the clockwise arbiter
//   grant_pe   per-VC grant from the PE arbiter
//   data_out   head flit of VC v at [v*DATA_WIDTH +: DATA_WIDTH] (0 when empty)
//   occupancy  registered entry count of VC v at [v*CW +: CW]
//   overflow   sticky: a flit was offered while VC[phase] was full
//   grant_err  sticky: a grant without matching request, or both grants on one VC
module cw_vc_input #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_VC     = 2,
    parameter int DEPTH      = 4,
    parameter int HOP_MSB    = 55,
    parameter int HOP_LSB    = 48,
    localparam int VW        = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [VW-1:0]                phase,
    input  logic                         cwsi,
    output logic                         cwri,
    input  logic [DATA_WIDTH-1:0]        cwdi,
    output logic [NUM_VC-1:0]            request_cw,
    output logic [NUM_VC-1:0]            request_pe,
    input  logic [NUM_VC-1:0]            grant_cw,
    input  logic [NUM_VC-1:0]            grant_pe,
    output logic [NUM_VC*DATA_WIDTH-1:0] data_out,
    output logic [NUM_VC*CW-1:0]         occupancy,
    output logic                         overflow,
    output logic                         grant_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int HW = HOP_MSB - HOP_LSB + 1;

    logic [NUM_VC*CW-1:0] count_flat;
    logic [NUM_VC-1:0]    push;
    logic [NUM_VC-1:0]    pop;
    logic [NUM_VC-1:0]    vc_err;
    logic [CW-1:0]        sel_count;
    logic                 sel_valid;
    logic                 overflow_reg;
    logic                 grant_err_reg;

    // Count of the VC addressed by phase. A phase value with no matching VC
    // (only possible when NUM_VC is not a power of two) reports not-ready.
    always_comb begin
        sel_valid = 1'b0;
        sel_count = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (phase == VW'(i)) begin
                sel_valid = 1'b1;
                sel_count = count_flat[i*CW +: CW];
            end
        end
    end

    assign cwri = sel_valid && (sel_count != CW'(DEPTH));

    generate
        for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
            logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
            logic [PW-1:0]         head_reg;
            logic [PW-1:0]         tail_reg;
            logic [CW-1:0]         count_reg;
            logic [DATA_WIDTH-1:0] head_flit;
            logic [DATA_WIDTH-1:0] out_flit;
            logic [HW-1:0]         hop;
            logic                  eligible;

            assign head_flit = mem_reg[head_reg];
            assign hop       = head_flit[HOP_MSB:HOP_LSB];

            // The phase VC is the one being written, so it never requests;
            // this keeps push and pop on a VC mutually exclusive.
            assign eligible       = (count_reg != '0) && (phase != VW'(gi));
            assign request_cw[gi] = eligible && (hop != '0);
            assign request_pe[gi] = eligible && (hop == '0);

            assign push[gi] = cwsi && (phase == VW'(gi)) && (count_reg != CW'(DEPTH));

            // A grant on a VC that is not requesting that output, or both
            // grants at once, is a protocol error and suppresses the pop.
            assign vc_err[gi] = (grant_cw[gi] & ~request_cw[gi])
                              | (grant_pe[gi] & ~request_pe[gi])
                              | (grant_cw[gi] &  grant_pe[gi]);
            assign pop[gi]    = ((grant_cw[gi] & request_cw[gi])
                              |  (grant_pe[gi] & request_pe[gi])) & ~vc_err[gi];

            // Flits forwarded clockwise leave with one hop consumed.
            always_comb begin
                out_flit = '0;
                if (count_reg != '0) begin
                    out_flit = head_flit;
                    if (hop != '0) begin
                        out_flit[HOP_MSB:HOP_LSB] = hop - HW'(1);
                    end
                end
            end

            assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] = out_flit;
            assign count_flat[gi*CW +: CW]               = count_reg;

            // Storage needs no reset: an entry is only visible once counted.
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem_reg[tail_reg] <= cwdi;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    head_reg  <= '0;
                    tail_reg  <= '0;
                    count_reg <= '0;
                end else begin
                    if (push[gi]) begin
                        tail_reg <= tail_reg + PW'(1);
                    end
                    if (pop[gi]) begin
                        head_reg <= head_reg + PW'(1);
                    end
                    if (push[gi] && !pop[gi]) begin
                        count_reg <= count_reg + CW'(1);
                    end else if (pop[gi] && !push[gi]) begin
                        count_reg <= count_reg - CW'(1);
                    end
                end
            end
        end
    endgenerate

    // Any offered flit that is not accepted was dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_reg  <= 1'b0;
            grant_err_reg <= 1'b0;
        end else begin
            if (cwsi && !cwri) begin
                overflow_reg <= 1'b1;
            end
            if (|vc_err) begin
                grant_err_reg <= 1'b1;
            end
        end
    end

    assign occupancy = count_flat;
    assign overflow  = overflow_reg;
    assign grant_err = grant_err_reg;

endmodule

// File: tb/tb_cw_vc_input.sv
module tb_cw_vc_input;

    logic         clk = 1'b0;
    logic         rst;
    logic [0:0]   phase;
    logic         cwsi;
    logic         cwri;
    logic [63:0]  cwdi;
    logic [1:0]   request_cw;
    logic [1:0]   request_pe;
    logic [1:0]   grant_cw;
    logic [1:0]   grant_pe;
    logic [127:0] data_out;
    logic [5:0]   occupancy;
    logic         overflow;
    logic         grant_err;

    int total  = 0;
    int passed = 0;

    cw_vc_input dut (
        .clk        (clk),
        .rst        (rst),
        .phase      (phase),
        .cwsi       (cwsi),
        .cwri       (cwri),
        .cwdi       (cwdi),
        .request_cw (request_cw),
        .request_pe (request_pe),
        .grant_cw   (grant_cw),
        .grant_pe   (grant_pe),
        .data_out   (data_out),
        .occupancy  (occupancy),
        .overflow   (overflow),
        .grant_err  (grant_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        phase;
        logic        cwsi;
        logic [63:0] cwdi;
        logic [1:0]  gcw;
        logic [1:0]  gpe;
        logic        e_cwri;
        logic [1:0]  e_rcw;
        logic [1:0]  e_rpe;
        logic [5:0]  e_occ;
        logic [63:0] e_d0;
        logic [63:0] e_d1;
        logic        e_ovf;
        logic        e_gerr;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [63:0] mk(input logic [7:0] h, input logic [47:0] p);
        return {8'hA5, h, p};
    endfunction

    // Expected clockwise view of a flit: hop consumed unless already zero.
    function automatic logic [63:0] fwd(input logic [63:0] f);
        logic [63:0] r;
        r = f;
        if (f[55:48] != 8'd0) r[55:48] = f[55:48] - 8'd1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
            $display("check %s: %h ok", nm, act);
        end else begin
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cwsi     = 1'b0;
        cwdi     = 64'd0;
        grant_cw = 2'b00;
        grant_pe = 2'b00;
    endtask

    task automatic do_reset();
        idle_inputs();
        phase = 1'b0;
        rst   = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    logic [63:0] f1, f1d, f2, w;
    logic [63:0] g [5];
    logic [63:0] wq [$];

    initial begin
        idle_inputs();
        phase = 1'b0;
        rst   = 1'b0;
        #2;
        chk("por_cwri", 64'(cwri), 64'd1);
        chk("por_occ", 64'(occupancy), 64'd0);
        do_reset();

        // ---------------- table-driven vectors ----------------
        f1  = mk(8'd3, 48'h1111_2222_3333);
        f1d = mk(8'd2, 48'h1111_2222_3333);
        f2  = mk(8'd0, 48'h4444_5555_6666);
        //           ph    cwsi  cwdi    gcw    gpe    cwri  rcw    rpe    occ   d0     d1      ovf   gerr
        vecs[0] = '{1'b0, 1'b1, f1,     2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 6'd0, 64'd0, 64'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 64'd0,  2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 6'd1, f1d,   64'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 64'd0,  2'b01, 2'b00, 1'b1, 2'b01, 2'b00, 6'd1, f1d,   64'd0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, f2,     2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 6'd0, 64'd0, 64'd0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 64'd0,  2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 6'd1, f2,    64'd0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 64'd0,  2'b00, 2'b01, 1'b1, 2'b00, 2'b01, 6'd1, f2,    64'd0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 64'd0,  2'b01, 2'b00, 1'b1, 2'b00, 2'b00, 6'd0, 64'd0, 64'd0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 64'd0,  2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 6'd0, 64'd0, 64'd0, 1'b0, 1'b1};

        for (int i = 0; i < 8; i++) begin
            phase    = vecs[i].phase;
            cwsi     = vecs[i].cwsi;
            cwdi     = vecs[i].cwdi;
            grant_cw = vecs[i].gcw;
            grant_pe = vecs[i].gpe;
            #1;
            chk($sformatf("v%0d_cwri", i), 64'(cwri), 64'(vecs[i].e_cwri));
            chk($sformatf("v%0d_rcw", i), 64'(request_cw), 64'(vecs[i].e_rcw));
            chk($sformatf("v%0d_rpe", i), 64'(request_pe), 64'(vecs[i].e_rpe));
            chk($sformatf("v%0d_occ", i), 64'(occupancy), 64'(vecs[i].e_occ));
            chk($sformatf("v%0d_d0", i), data_out[63:0], vecs[i].e_d0);
            chk($sformatf("v%0d_d1", i), data_out[127:64], vecs[i].e_d1);
            chk($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vecs[i].e_ovf));
            chk($sformatf("v%0d_gerr", i), 64'(grant_err), 64'(vecs[i].e_gerr));
            step();
        end
        idle_inputs();

        // ---------------- fill VC1, overflow, drain in order ----------------
        do_reset();
        for (int k = 0; k < 5; k++) g[k] = mk(8'(k + 1), 48'(k + 48'hBEE0));
        phase = 1'b1;
        cwsi  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cwdi = g[k];
            step();
        end
        chk("full_cwri", 64'(cwri), 64'd0);
        chk("full_occ", 64'(occupancy), 64'd32);
        cwdi = g[4];
        step();
        cwsi = 1'b0;
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_occ", 64'(occupancy), 64'd32);
        phase = 1'b0;
        #1;
        chk("other_vc_cwri", 64'(cwri), 64'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d_rcw", k), 64'(request_cw), 64'd2);
            chk($sformatf("drain%0d_d1", k), data_out[127:64], mk(8'(k), 48'(k + 48'hBEE0)));
            grant_cw = 2'b10;
            step();
            grant_cw = 2'b00;
        end
        chk("drained_occ", 64'(occupancy), 64'd0);
        chk("drained_rcw", 64'(request_cw), 64'd0);
        phase = 1'b1;
        #1;
        chk("drained_cwri", 64'(cwri), 64'd1);

        // ---------------- pointer wrap on VC0 ----------------
        for (int p = 0; p < 10; p++) begin
            phase = 1'b0;
            cwsi  = 1'b1;
            for (int k = 0; k < 3; k++) begin
                w    = mk(8'((p * 3 + k) % 3), 48'(p * 16 + k + 48'h7000));
                cwdi = w;
                wq.push_back(w);
                step();
            end
            cwsi  = 1'b0;
            phase = 1'b1;
            #1;
            chk($sformatf("wrap%0d_occ", p), 64'(occupancy), 64'd3);
            for (int k = 0; k < 3; k++) begin
                w = wq.pop_front();
                chk($sformatf("wrap%0d_%0d_d0", p, k), data_out[63:0], fwd(w));
                chk($sformatf("wrap%0d_%0d_rpe", p, k), 64'(request_pe[0]), 64'(w[55:48] == 8'd0));
                if (w[55:48] == 8'd0) grant_pe = 2'b01;
                else                  grant_cw = 2'b01;
                step();
                grant_cw = 2'b00;
                grant_pe = 2'b00;
            end
            chk($sformatf("wrap%0d_empty", p), 64'(occupancy), 64'd0);
        end

        // ---------------- double grant ----------------
        do_reset();
        phase = 1'b0;
        cwsi  = 1'b1;
        cwdi  = mk(8'd3, 48'hD0D0);
        step();
        cwsi  = 1'b0;
        phase = 1'b1;
        grant_cw = 2'b01;
        grant_pe = 2'b01;
        step();
        idle_inputs();
        chk("dbl_gerr", 64'(grant_err), 64'd1);
        chk("dbl_occ", 64'(occupancy), 64'd1);
        chk("dbl_rcw", 64'(request_cw), 64'd1);

        // ---------------- asynchronous reset mid-cycle ----------------
        do_reset();
        phase = 1'b0;
        cwsi  = 1'b1;
        cwdi  = mk(8'd5, 48'hA0);
        step();
        step();
        phase = 1'b1;
        cwdi  = mk(8'd0, 48'hB0);
        step();
        step();
        step();
        cwsi     = 1'b0;
        grant_pe = 2'b01;   // VC0 head has hop!=0, so this grant is illegal
        step();
        grant_pe = 2'b00;
        chk("pre_rst_occ", 64'(occupancy), 64'd26);
        chk("pre_rst_gerr", 64'(grant_err), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_cwri", 64'(cwri), 64'd1);
        chk("arst_rcw", 64'(request_cw), 64'd0);
        chk("arst_rpe", 64'(request_pe), 64'd0);
        chk("arst_d0", data_out[63:0], 64'd0);
        chk("arst_d1", data_out[127:64], 64'd0);
        chk("arst_occ", 64'(occupancy), 64'd0);
        chk("arst_gerr", 64'(grant_err), 64'd0);
        chk("arst_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_cwri", 64'(cwri), 64'd1);
        chk("rel_occ", 64'(occupancy), 64'd0);
        phase = 1'b0;
        cwsi  = 1'b1;
        cwdi  = mk(8'd1, 48'hC0);
        step();
        cwsi  = 1'b0;
        phase = 1'b1;
        #1;
        chk("rel_first_occ", 64'(occupancy), 64'd1);
        chk("rel_first_d0", data_out[63:0], mk(8'd0, 48'hC0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
